// File: rtl/membus_dma_initiator.sv
// Word-copy DMA initiator on the PicoRV32 native memory bus.
// Optional fill mode (no reads, constant write data) via MEMBUS_DMA_FILL_EN.
module membus_dma_initiator #(
  parameter int LEN_WIDTH = 16,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [31:0]          src_addr,
  input  logic [31:0]          dst_addr,
  input  logic [LEN_WIDTH-1:0] word_count,
`ifdef MEMBUS_DMA_FILL_EN
  input  logic                 fill,
  input  logic [31:0]          fill_value,
`endif
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic                 mem_valid,
  input  logic                 mem_ready,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  output logic [3:0]           mem_wstrb,
  input  logic [31:0]          mem_rdata
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLIM = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t               state;
  logic [31:0]          src_ptr;
  logic [31:0]          dst_ptr;
  logic [LEN_WIDTH-1:0] remaining;
  logic [TW-1:0]        tcnt;
  logic                 fill_in;
  logic                 fill_q;
  logic [31:0]          fill_data;
  logic                 tm_hit;
  logic                 unused;

  assign unused = ^{src_addr[1:0], dst_addr[1:0]};

`ifdef MEMBUS_DMA_FILL_EN
  assign fill_in   = fill;
  assign fill_data = fill_value;
`else
  assign fill_in   = 1'b0;
  assign fill_data = 32'h0;
`endif

  // The cycle that completes the count without mem_ready is the abort cycle.
  assign tm_hit = (TIMEOUT != 0) && !mem_ready && (tcnt == TLIM);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      mem_valid <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      mem_wstrb <= 4'h0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      src_ptr   <= 32'h0;
      dst_ptr   <= 32'h0;
      remaining <= '0;
      tcnt      <= '0;
      fill_q    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (word_count == '0) begin
              done <= 1'b1;
            end else begin
              src_ptr   <= {src_addr[31:2], 2'b00};
              dst_ptr   <= {dst_addr[31:2], 2'b00};
              remaining <= word_count;
              error     <= 1'b0;
              busy      <= 1'b1;
              mem_valid <= 1'b1;
              tcnt      <= '0;
              fill_q    <= fill_in;
              if (fill_in) begin
                state     <= WRITE;
                mem_addr  <= {dst_addr[31:2], 2'b00};
                mem_wdata <= fill_data;
                mem_wstrb <= 4'hF;
              end else begin
                state     <= READ;
                mem_addr  <= {src_addr[31:2], 2'b00};
                mem_wstrb <= 4'h0;
              end
            end
          end
        end
        READ: begin
          if (mem_ready) begin
            mem_wdata <= mem_rdata;
            mem_addr  <= dst_ptr;
            mem_wstrb <= 4'hF;
            tcnt      <= '0;
            state     <= WRITE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        WRITE: begin
          if (mem_ready) begin
            src_ptr   <= src_ptr + 32'd4;
            dst_ptr   <= dst_ptr + 32'd4;
            remaining <= remaining - 1'b1;
            tcnt      <= '0;
            if (remaining == LEN_WIDTH'(1)) begin
              mem_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= IDLE;
            end else if (fill_q) begin
              mem_addr <= dst_ptr + 32'd4;
            end else begin
              mem_addr  <= src_ptr + 32'd4;
              mem_wstrb <= 4'h0;
              state     <= READ;
            end
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
      // Stalled responder: abandon the rest of the block.
      if (state != IDLE && tm_hit) begin
        mem_valid <= 1'b0;
        busy      <= 1'b0;
        done      <= 1'b1;
        error     <= 1'b1;
        state     <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_membus_dma_initiator.sv
// Randomized self-checking bench for membus_dma_initiator.
// Memory responder + transaction log checked against a word-copy model.
module tb_membus_dma_initiator;

  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [31:0]   src_addr;
  logic [31:0]   dst_addr;
  logic [LW-1:0] word_count;
  logic          busy;
  logic          done;
  logic          error;
  logic          mem_valid;
  logic          mem_ready;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_wstrb;
  logic [31:0]   mem_rdata;
`ifdef MEMBUS_DMA_FILL_EN
  logic          fill;
  logic [31:0]   fill_value;
  logic          fill_mode = 1'b0;
  logic [31:0]   fv_mode = 32'h0;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  membus_dma_initiator #(.LEN_WIDTH(LW), .TIMEOUT(8)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .src_addr(src_addr),
    .dst_addr(dst_addr),
    .word_count(word_count),
`ifdef MEMBUS_DMA_FILL_EN
    .fill(fill),
    .fill_value(fill_value),
`endif
    .busy(busy),
    .done(done),
    .error(error),
    .mem_valid(mem_valid),
    .mem_ready(mem_ready),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } tx_t;

  logic [31:0] ram [logic [31:0]];
  logic [31:0] mdl [logic [31:0]];
  tx_t         log_q [$];
  tx_t         exp_q [$];

  int lat = 0;
  bit stall = 1'b0;
  int wcnt = 0;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return {a[15:0], ~a[31:16]};
  endfunction

  // Responder: ready lat+1 cycles after a request is seen, one cycle wide.
  always @(posedge clk) begin
    if (reset) begin
      mem_ready <= 1'b0;
      wcnt <= 0;
    end else if (mem_ready) begin
      mem_ready <= 1'b0;
      wcnt <= 0;
    end else if (mem_valid && !stall) begin
      if (wcnt >= lat) begin
        mem_ready <= 1'b1;
        if (mem_wstrb != 4'h0) ram[mem_addr] = mem_wdata;
        else mem_rdata <= ram.exists(mem_addr) ? ram[mem_addr] : pat(mem_addr);
      end else begin
        wcnt <= wcnt + 1;
      end
    end
  end

  int   done_cnt = 0;
  int   busy_cyc = 0;
  int   valid_cyc = 0;
  int   stab_err = 0;
  logic pv = 1'b0;
  tx_t  pt;

  always @(posedge clk) begin
    if (!reset) begin
      if (done) done_cnt++;
      if (busy) busy_cyc++;
      if (mem_valid) valid_cyc++;
      if (mem_valid && mem_ready)
        log_q.push_back({mem_addr, (mem_wstrb != 4'h0) ? mem_wdata : mem_rdata, mem_wstrb});
      if (pv && mem_valid && ({mem_addr, mem_wdata, mem_wstrb} !== pt)) stab_err++;
    end
    pv = mem_valid && !mem_ready && !reset;
    pt = {mem_addr, mem_wdata, mem_wstrb};
  end

  // Reference: words copied strictly in order, read then write.
  task automatic model_copy(input logic [31:0] s, input logic [31:0] d,
                            input int n, input bit f, input logic [31:0] fv);
    logic [31:0] sa;
    logic [31:0] da;
    logic [31:0] v;
    sa = {s[31:2], 2'b00};
    da = {d[31:2], 2'b00};
    mdl = ram;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      if (f) begin
        v = fv;
      end else begin
        v = mdl.exists(sa) ? mdl[sa] : pat(sa);
        exp_q.push_back({sa, v, 4'h0});
      end
      mdl[da] = v;
      exp_q.push_back({da, v, 4'hF});
      sa = sa + 32'd4;
      da = da + 32'd4;
    end
  endtask

  function automatic int log_diff(input int base);
    int m = 0;
    if (log_q.size() - base != exp_q.size()) return 1000 + log_q.size() - base;
    foreach (exp_q[i]) if (log_q[base + i] !== exp_q[i]) m++;
    return m;
  endfunction

  function automatic int ram_diff();
    int m = 0;
    if (ram.size() != mdl.size()) m++;
    foreach (mdl[k]) if (!ram.exists(k) || ram[k] !== mdl[k]) m++;
    return m;
  endfunction

  task automatic kick(input logic [31:0] s, input logic [31:0] d, input int n);
    @(negedge clk);
    start = 1'b1;
    src_addr = s;
    dst_addr = d;
    word_count = LW'(n);
`ifdef MEMBUS_DMA_FILL_EN
    fill = fill_mode;
    fill_value = fv_mode;
`endif
    @(negedge clk);
    start = 1'b0;
    src_addr = $urandom;
    dst_addr = $urandom;
    word_count = LW'($urandom);
`ifdef MEMBUS_DMA_FILL_EN
    fill = ~fill_mode;
    fill_value = $urandom;
`endif
  endtask

  task automatic wait_done(input int d0, output bit ok);
    for (int i = 0; i < 3000 && done_cnt == d0; i++) @(posedge clk);
    ok = (done_cnt != d0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [31:0] obs [7];
    string nm [7] = '{"rst_valid", "rst_addr", "rst_wdata", "rst_wstrb",
                      "rst_busy", "rst_done", "rst_error"};
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    obs = '{32'(mem_valid), mem_addr, mem_wdata, 32'(mem_wstrb),
            32'(busy), 32'(done), 32'(error)};
    for (int i = 0; i < 7; i++) begin
      total++;
      if (obs[i] !== 32'h0) begin
        bad++;
        $display("FAIL %s: got %0h want 0", nm[i], obs[i]);
      end
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_copy;
    logic [31:0] ea [6] = '{32'h40, 32'h100, 32'h44, 32'h104, 32'h48, 32'h108};
    logic [31:0] ed [6] = '{32'h11111111, 32'h11111111, 32'h22222222,
                            32'h22222222, 32'h33333333, 32'h33333333};
    int base = log_q.size();
    int d0 = done_cnt;
    int b0 = busy_cyc;
    bit ok;
    lat = 0;
    ram[32'h40] = 32'h11111111;
    ram[32'h44] = 32'h22222222;
    ram[32'h48] = 32'h33333333;
    kick(32'h40, 32'h100, 3);
    total++;
    if (!(mem_valid === 1'b1 && busy === 1'b1 && mem_addr === 32'h40 && mem_wstrb === 4'h0)) begin
      bad++;
      $display("FAIL copy_first_req: got v=%b b=%b a=%h s=%h want v=1 b=1 a=40 s=0",
               mem_valid, busy, mem_addr, mem_wstrb);
    end
    wait_done(d0, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL copy_done_wait: got no done want done"); end
    total++;
    if (log_q.size() - base !== 6) begin
      bad++;
      $display("FAIL copy_tx_count: got %0d want 6", log_q.size() - base);
    end else begin
      for (int i = 0; i < 6; i++) begin
        total++;
        if (log_q[base+i] !== {ea[i], ed[i], (i % 2 == 1) ? 4'hF : 4'h0}) begin
          bad++;
          $display("FAIL copy_tx%0d: got %h want %h", i, log_q[base+i],
                   {ea[i], ed[i], (i % 2 == 1) ? 4'hF : 4'h0});
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (ram[32'h100 + 32'(4*i)] !== ed[2*i]) begin
        bad++;
        $display("FAIL copy_ram%0d: got %h want %h", i, ram[32'h100 + 32'(4*i)], ed[2*i]);
      end
    end
    total++;
    if (done_cnt - d0 !== 1) begin
      bad++;
      $display("FAIL copy_done_pulses: got %0d want 1", done_cnt - d0);
    end
    total++;
    if (busy_cyc - b0 !== 12) begin
      bad++;
      $display("FAIL copy_busy_cycles: got %0d want 12", busy_cyc - b0);
    end
    total++;
    if (error !== 1'b0) begin bad++; $display("FAIL copy_error: got %b want 0", error); end
  endtask

  task automatic test_zero_len;
    int v0 = valid_cyc;
    int d0 = done_cnt;
    kick($urandom, $urandom, 0);
    total++;
    if (!(done === 1'b1 && busy === 1'b0 && mem_valid === 1'b0)) begin
      bad++;
      $display("FAIL zero_pulse: got d=%b b=%b v=%b want d=1 b=0 v=0", done, busy, mem_valid);
    end
    @(posedge clk);
    #1;
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL zero_pulse_width: got %b want 0", done); end
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (valid_cyc - v0 !== 0 || done_cnt - d0 !== 1) begin
      bad++;
      $display("FAIL zero_no_bus: got valid=%0d done=%0d want 0 1", valid_cyc - v0, done_cnt - d0);
    end
  endtask

  task automatic test_start_busy;
    logic [31:0] s = 32'h3000 + 32'($urandom_range(0, 15)) * 4;
    logic [31:0] d = 32'h3400 + 32'($urandom_range(0, 15)) * 4;
    int base = log_q.size();
    int d0 = done_cnt;
    bit ok;
    lat = $urandom_range(0, 2);
    model_copy(s, d, 4, 1'b0, 32'h0);
    kick(s, d, 4);
    repeat (4) @(negedge clk);
    start = 1'b1;
    src_addr = 32'h5000;
    dst_addr = 32'h6000;
    word_count = LW'(7);
    @(negedge clk);
    start = 1'b0;
    wait_done(d0, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL busy_done_wait: got no done want done"); end
    total++;
    if (log_diff(base) !== 0) begin
      bad++;
      $display("FAIL busy_tx_seq: got %0d diffs want 0", log_diff(base));
    end
    total++;
    if (ram_diff() !== 0) begin bad++; $display("FAIL busy_ram: got %0d diffs want 0", ram_diff()); end
    total++;
    if (done_cnt - d0 !== 1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL busy_single_done: got %0d busy=%b want 1 busy=0", done_cnt - d0, busy);
    end
  endtask

  task automatic test_timeout;
    int v0 = valid_cyc;
    int d0 = done_cnt;
    int base;
    bit ok;
    stall = 1'b1;
    kick($urandom, $urandom, 3);
    wait_done(d0, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL tmo_done_wait: got no done want done"); end
    total++;
    if (valid_cyc - v0 !== 8) begin
      bad++;
      $display("FAIL tmo_valid_cycles: got %0d want 8", valid_cyc - v0);
    end
    total++;
    if (!(error === 1'b1 && busy === 1'b0 && mem_valid === 1'b0 && done_cnt - d0 == 1)) begin
      bad++;
      $display("FAIL tmo_flags: got e=%b b=%b v=%b d=%0d want e=1 b=0 v=0 d=1",
               error, busy, mem_valid, done_cnt - d0);
    end
    stall = 1'b0;
    lat = 1;
    base = log_q.size();
    d0 = done_cnt;
    model_copy(32'h700, 32'h780, 2, 1'b0, 32'h0);
    kick(32'h700, 32'h780, 2);
    total++;
    if (error !== 1'b0) begin bad++; $display("FAIL tmo_error_clear: got %b want 0", error); end
    wait_done(d0, ok);
    total++;
    if (!ok || log_diff(base) !== 0 || error !== 1'b0) begin
      bad++;
      $display("FAIL tmo_recover: got ok=%b diffs=%0d e=%b want 1 0 0", ok, log_diff(base), error);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] obs [7];
    bit found = 1'b0;
    int d0;
    int v0;
    int base;
    bit ok;
    lat = 1;
    kick(32'h900, 32'hA00, 5);
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (mem_valid && mem_wstrb == 4'hF) found = 1'b1;
    end
    total++;
    if (!found) begin bad++; $display("FAIL rmid_write_seen: got none want write"); end
    d0 = done_cnt;
    reset = 1'b1;
    @(posedge clk);
    #1;
    obs = '{32'(mem_valid), mem_addr, mem_wdata, 32'(mem_wstrb),
            32'(busy), 32'(done), 32'(error)};
    for (int i = 0; i < 7; i++) begin
      total++;
      if (obs[i] !== 32'h0) begin
        bad++;
        $display("FAIL rmid_out%0d: got %0h want 0", i, obs[i]);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    v0 = valid_cyc;
    repeat (10) @(posedge clk);
    #1;
    total++;
    if (done_cnt - d0 !== 0 || valid_cyc - v0 !== 0) begin
      bad++;
      $display("FAIL rmid_quiet: got done=%0d valid=%0d want 0 0", done_cnt - d0, valid_cyc - v0);
    end
    base = log_q.size();
    d0 = done_cnt;
    model_copy(32'hB00, 32'hC00, 3, 1'b0, 32'h0);
    kick(32'hB00, 32'hC00, 3);
    wait_done(d0, ok);
    total++;
    if (!ok || log_diff(base) !== 0 || ram_diff() !== 0) begin
      bad++;
      $display("FAIL rmid_after: got ok=%b diffs=%0d ram=%0d want 1 0 0",
               ok, log_diff(base), ram_diff());
    end
  endtask

  task automatic test_random;
    logic [31:0] s;
    logic [31:0] d;
    int n;
    int base;
    int d0;
    bit ok;
    for (int t = 0; t < 25; t++) begin
      lat = $urandom_range(0, 3);
      n = $urandom_range(1, 6);
      if (t % 8 == 0) begin
        s = 32'hFFFF_FFF8 + 32'($urandom_range(0, 3));
        d = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3));
      end else begin
        s = 32'h2000 + 32'($urandom_range(0, 31)) * 4 + 32'($urandom_range(0, 3));
        d = 32'h2000 + 32'($urandom_range(0, 31)) * 4 + 32'($urandom_range(0, 3));
      end
      base = log_q.size();
      d0 = done_cnt;
      model_copy(s, d, n, 1'b0, 32'h0);
      kick(s, d, n);
      wait_done(d0, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL rnd%0d_done_wait: got no done want done", t); end
      total++;
      if (log_diff(base) !== 0) begin
        bad++;
        $display("FAIL rnd%0d_tx_seq: got %0d diffs want 0 (s=%h d=%h n=%0d)",
                 t, log_diff(base), s, d, n);
      end
      total++;
      if (ram_diff() !== 0) begin
        bad++;
        $display("FAIL rnd%0d_ram: got %0d diffs want 0", t, ram_diff());
      end
      total++;
      if (done_cnt - d0 !== 1 || error !== 1'b0) begin
        bad++;
        $display("FAIL rnd%0d_status: got done=%0d e=%b want 1 0", t, done_cnt - d0, error);
      end
    end
  endtask

`ifdef MEMBUS_DMA_FILL_EN
  task automatic test_fill;
    int base = log_q.size();
    int d0 = done_cnt;
    int b0 = busy_cyc;
    bit ok;
    lat = 0;
    fill_mode = 1'b1;
    fv_mode = 32'hA5A5A5A5;
    model_copy($urandom, 32'h1000_0000, 2, 1'b1, 32'hA5A5A5A5);
    kick(32'h40, 32'h1000_0000, 2);
    fill_mode = 1'b0;
    wait_done(d0, ok);
    total++;
    if (!ok || log_diff(base) !== 0) begin
      bad++;
      $display("FAIL fill_tx_seq: got ok=%b diffs=%0d want 1 0", ok, log_diff(base));
    end
    total++;
    if (busy_cyc - b0 !== 4 || done_cnt - d0 !== 1) begin
      bad++;
      $display("FAIL fill_timing: got busy=%0d done=%0d want 4 1", busy_cyc - b0, done_cnt - d0);
    end
  endtask
`endif

  task automatic test_stability;
    total++;
    if (stab_err !== 0) begin
      bad++;
      $display("FAIL bus_stable: got %0d changes while stalled want 0", stab_err);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    src_addr = 32'h0;
    dst_addr = 32'h0;
    word_count = '0;
`ifdef MEMBUS_DMA_FILL_EN
    fill = 1'b0;
    fill_value = 32'h0;
`endif
    test_reset;
    test_copy;
    test_zero_len;
    test_start_busy;
    test_timeout;
    test_reset_mid;
    test_random;
`ifdef MEMBUS_DMA_FILL_EN
    test_fill;
`endif
    test_stability;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
